// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA controller: copies one 256-byte page into the PPU OAM data port
// while stalling the CPU. Define DMA_ALIGN_EN to compile in the even-cycle ALIGN state.
module oam_dma_ctrl #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [7:0]  mem_din,
    output logic        rdy_o,
    output logic        bus_grant,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_dout,
    output logic        dma_we,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        grant_q, grant_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
`ifdef DMA_ALIGN_EN
    logic        cyc_odd_q, cyc_odd_d;

    // Free-running cycle parity, cleared only by reset
    always_comb begin
        cyc_odd_d = ~cyc_odd_q;
    end
`endif

    // Next-state, transfer bookkeeping and completion pulse
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_we && (cpu_addr == TRIGGER_ADDR)) begin
                    page_d  = cpu_dout;
                    cnt_d   = 8'h00;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                // The CPU only honours rdy on a read cycle, so wait out its writes.
                if (cpu_we) begin
                    state_d = ST_HALT;
                end else begin
`ifdef DMA_ALIGN_EN
                    if (cyc_odd_q) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_ALIGN;
                    end
`else
                    state_d = ST_READ;
`endif
                end
            end
            ST_ALIGN: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                data_d  = mem_din;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register in step with it
    always_comb begin
        rdy_d   = (state_d == ST_IDLE);
        grant_d = (state_d == ST_ALIGN) || (state_d == ST_READ) || (state_d == ST_WRITE);
        case (state_d)
            ST_READ: begin
                addr_d = {page_d, cnt_d};
                we_d   = 1'b0;
            end
            ST_WRITE: begin
                addr_d = OAM_DATA_ADDR;
                we_d   = 1'b1;
            end
            default: begin
                addr_d = 16'h0000;
                we_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            page_q    <= 8'h00;
            cnt_q     <= 8'h00;
            data_q    <= 8'h00;
            rdy_q     <= 1'b1;
            grant_q   <= 1'b0;
            addr_q    <= 16'h0000;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef DMA_ALIGN_EN
            cyc_odd_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            done_q    <= done_d;
`ifdef DMA_ALIGN_EN
            cyc_odd_q <= cyc_odd_d;
`endif
        end
    end

    assign rdy_o     = rdy_q;
    assign bus_grant = grant_q;
    assign dma_addr  = addr_q;
    assign dma_dout  = data_q;
    assign dma_we    = we_q;
    assign dma_done  = done_q;

endmodule
